// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port program/data RAM between the BIOS
// loader (B), the CPU fetch port (I) and the CPU load/store port (D).
// B has fixed priority, I and D alternate, and CPU ports wait for boot-complete.
// Read data comes back one cycle after the grant, tagged to the issuing port.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_booted,

    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic                    b_gnt,
    output logic                    b_rvalid,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,

    output logic [DATA_WIDTH-1:0]   o_rdata,

    output logic                    ram_en,
    output logic                    ram_we,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        SRC_B = 2'd0,
        SRC_I = 2'd1,
        SRC_D = 2'd2
    } src_e;

    // rr_last: 0 after an I grant, 1 after a D grant; the other port wins a tie.
    logic                  rr_last;
    logic                  tag_valid;
    src_e                  tag_src;
    logic                  rvalid_any;
    logic [DATA_WIDTH-1:0] rdata_hold;

    // Grant selection: BIOS first, then the CPU ports only once booted.
    always_comb begin
        b_gnt = 1'b0;
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (b_req) begin
                b_gnt = 1'b1;
            end else if (i_booted) begin
                if (i_req && d_req) begin
                    if (rr_last) begin
                        i_gnt = 1'b1;
                    end else begin
                        d_gnt = 1'b1;
                    end
                end else if (i_req) begin
                    i_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
            end
        end
    end

    // RAM request mux: the granted port drives the macro, otherwise all zero.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (b_gnt) begin
            ram_en    = 1'b1;
            ram_we    = b_we;
            ram_be    = b_be;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end else if (i_gnt) begin
            ram_en    = 1'b1;
            ram_we    = 1'b0;
            ram_be    = {BE_WIDTH{1'b1}};
            ram_addr  = i_addr;
        end else if (d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = d_we;
            ram_be    = d_be;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    // Read tag and round-robin pointer; BIOS grants do not move the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag_src   <= SRC_B;
            rr_last   <= 1'b1;
        end else begin
            tag_valid <= ram_en && !ram_we;
            if (b_gnt) begin
                tag_src <= SRC_B;
            end else if (i_gnt) begin
                tag_src <= SRC_I;
            end else if (d_gnt) begin
                tag_src <= SRC_D;
            end
            if (i_gnt) begin
                rr_last <= 1'b0;
            end else if (d_gnt) begin
                rr_last <= 1'b1;
            end
        end
    end

    // A tag left over from the cycle before reset must not surface during reset.
    assign rvalid_any = tag_valid && !rst;
    assign b_rvalid   = rvalid_any && (tag_src == SRC_B);
    assign i_rvalid   = rvalid_any && (tag_src == SRC_I);
    assign d_rvalid   = rvalid_any && (tag_src == SRC_D);

    // Remember the last delivered word so o_rdata holds between returns.
    always_ff @(posedge clk) begin
        if (rvalid_any) begin
            rdata_hold <= ram_rdata;
        end
    end

    assign o_rdata = rvalid_any ? ram_rdata : rdata_hold;

endmodule
